d_latch: RTL and testbench

//   Clock-synchronous model of a level-enabled D latch with a parameterised data width.

---
 rtl/d_latch_if.sv | 11 +
 rtl/d_latch.sv | 23 ++
 tb/tb_d_latch.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/d_latch_if.sv
// Data/enable bundle for d_latch: the master drives En/D, the latch returns Q.
interface d_latch_if #(
  parameter int unsigned WIDTH = 1
);
  logic             En;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;

  modport master (output En, output D, input Q);
  modport slave  (input En, input D, output Q);
endinterface

// File: rtl/d_latch.sv
// Clock-synchronous model of a level-enabled D latch: Q follows D one edge later
// while En is high and holds while En is low; no true latch is inferred.
module d_latch #(
  parameter int unsigned WIDTH   = 1,
  parameter logic [63:0] RST_VAL = '0
) (
  input  logic      clk,
  input  logic      rst,
  d_latch_if.slave  bus
);

  localparam logic [WIDTH-1:0] RESET_Q = RST_VAL[WIDTH-1:0];

  // Q is the register itself, so there is no combinational path from D or En.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.Q <= RESET_Q;
    end else if (bus.En) begin
      bus.Q <= bus.D;
    end
  end

endmodule

// File: tb/tb_d_latch.sv
// Scoreboard bench for d_latch: a 1-bit instance and an 8-bit instance with RST_VAL=8'hA5.
module tb_d_latch;

  logic clk;
  logic rst1;
  logic rst8;
  int unsigned cycle;
  int unsigned passed;
  int unsigned total;

  typedef struct {
    logic [7:0]  exp;
    int unsigned due;
    string       name;
  } exp_t;

  exp_t q1[$];
  exp_t q8[$];

  d_latch_if #(.WIDTH(1)) bus1 ();
  d_latch_if #(.WIDTH(8)) bus8 ();

  d_latch #(.WIDTH(1)) dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (bus1.slave)
  );

  d_latch #(.WIDTH(8), .RST_VAL(64'hA5)) dut8 (
    .clk (clk),
    .rst (rst8),
    .bus (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Inputs change 2 time units after an edge; expectation is due at the following edge.
  task automatic step1(input logic r, input logic en, input logic d, input logic e,
                       input string name);
    exp_t it;
    @(posedge clk);
    #2;
    rst1    = r;
    bus1.En = en;
    bus1.D  = d;
    it.exp  = {7'b0, e};
    it.due  = cycle + 1;
    it.name = name;
    q1.push_back(it);
  endtask

  task automatic step8(input logic r, input logic en, input logic [7:0] d,
                       input logic [7:0] e, input string name);
    exp_t it;
    @(posedge clk);
    #2;
    rst8    = r;
    bus8.En = en;
    bus8.D  = d;
    it.exp  = e;
    it.due  = cycle + 1;
    it.name = name;
    q8.push_back(it);
  endtask

  // Monitor: Q is registered, so mid-cycle (negedge) is a stable sampling point.
  always @(negedge clk) begin
    exp_t it;
    while (q1.size() > 0 && q1[0].due <= cycle) begin
      it = q1.pop_front();
      total++;
      if (bus1.Q !== it.exp[0])
        $display("FAIL %s: got %b expected %b (cycle %0d)", it.name, bus1.Q, it.exp[0], cycle);
      else
        passed++;
    end
    while (q8.size() > 0 && q8[0].due <= cycle) begin
      it = q8.pop_front();
      total++;
      if (bus8.Q !== it.exp)
        $display("FAIL %s: got %h expected %h (cycle %0d)", it.name, bus8.Q, it.exp, cycle);
      else
        passed++;
    end
    if ((rst1 === 1'b0 && $isunknown(bus1.En)) || (rst8 === 1'b0 && $isunknown(bus8.En))) begin
      total++;
      $display("FAIL en_protocol: X/Z on En while out of reset (cycle %0d)", cycle);
    end
  end

  initial begin
    int unsigned waited;
    passed  = 0;
    total   = 0;
    rst1    = 1'b1;
    rst8    = 1'b1;
    bus1.En = 1'b0;
    bus1.D  = 1'b0;
    bus8.En = 1'b0;
    bus8.D  = 8'h00;

    step1(1, 1, 1, 0, "reset_first_edge");
    step1(1, 1, 1, 0, "reset_held");
    step1(0, 0, 0, 0, "hold_d0");
    step1(0, 0, 1, 0, "hold_d1");
    step1(0, 1, 0, 0, "capture_0");
    step1(0, 1, 1, 1, "capture_1");
    step1(0, 0, 0, 1, "hold1_a");
    step1(0, 0, 0, 1, "hold1_b");
    step1(0, 0, 0, 1, "hold1_c");
    step1(0, 1, 1, 1, "recapture_1");
    step1(1, 1, 1, 0, "reset_priority");
    step1(0, 1, 1, 1, "resume_after_reset");
    step1(0, 1, 0, 0, "capture_0_again");
    step1(0, 0, 1, 0, "en_fall_no_capture");

    step8(1, 0, 8'h00, 8'hA5, "w8_reset_val");
    step8(1, 1, 8'h77, 8'hA5, "w8_reset_over_en");
    step8(0, 1, 8'h3C, 8'h3C, "w8_capture_3c");
    step8(0, 0, 8'hFF, 8'h3C, "w8_hold_ff");
    step8(0, 0, 8'h00, 8'h3C, "w8_hold_00");
    step8(0, 1, 8'hC3, 8'hC3, "w8_capture_c3");
    step8(0, 1, 8'hFF, 8'hFF, "w8_capture_ff");
    step8(1, 1, 8'h01, 8'hA5, "w8_reset_mid");

    waited = 0;
    while ((q1.size() > 0 || q8.size() > 0) && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    if (q1.size() > 0 || q8.size() > 0) begin
      total++;
      $display("FAIL drain_timeout: %0d/%0d entries left, expected 0", q1.size(), q8.size());
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
